// File: rtl/bi_keccak_pkg.sv
// Shared Keccak lane definitions: rho offset table, beat payload types and the
// bit-interleave helper functions used by the rotate-unit front end.
package bi_keccak_pkg;

    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;
    localparam int SHIFT_W   = 6;

    typedef logic [4:0] lane_idx_t;

    // Rotate-left offsets for rho, indexed by x+5y.
    localparam logic [5:0] RHO_OFFSETS [NUM_LANES] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    typedef struct packed {
        logic              err;
        lane_idx_t         idx;
        logic [LANE_W-1:0] lane;
    } s1_beat_t;

    typedef struct packed {
        logic               last;
        logic [SHIFT_W-1:0] shift;
        s1_beat_t           beat;
    } s2_beat_t;

    function automatic logic [LANE_W-1:0] bi_interleave(input logic [LANE_W-1:0] lane);
        logic [LANE_W-1:0] res;
        res = '0;
        for (int j = 0; j < LANE_W / 2; j++) begin
            res[j]              = lane[2*j];
            res[LANE_W / 2 + j] = lane[2*j + 1];
        end
        return res;
    endfunction

    function automatic logic [LANE_W-1:0] bi_deinterleave(input logic [LANE_W-1:0] lane);
        logic [LANE_W-1:0] res;
        res = '0;
        for (int j = 0; j < LANE_W / 2; j++) begin
            res[2*j]     = lane[j];
            res[2*j + 1] = lane[LANE_W / 2 + j];
        end
        return res;
    endfunction

    // Rotating right by (64 - rho) mod 64 equals rotating left by rho; 6-bit wrap keeps rho=0 at 0.
    function automatic logic [SHIFT_W-1:0] rho_to_rotr(input lane_idx_t idx);
        logic [SHIFT_W-1:0] res;
        res = '0;
        if (idx < lane_idx_t'(NUM_LANES))
            res = 6'd0 - RHO_OFFSETS[idx];
        return res;
    endfunction

endpackage

// File: rtl/bi_pipe_reg.sv
// Single valid/ready register slice; accepts a new word whenever it is empty
// or its current word is leaving in the same cycle.
module bi_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    import bi_keccak_pkg::*;

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/bi_lane_interleaver.sv
// Lane tagger and bit-interleaver feeding the interleaved rotate unit.
// Optional BI_DEINTERLEAVE_EN adds in_dir to select the inverse mapping.
module bi_lane_interleaver #(
    parameter int LANE_W    = 64,
    parameter int NUM_LANES = 25,
    parameter int SHIFT_W   = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sof,
    input  logic [LANE_W-1:0]  in_lane,
`ifdef BI_DEINTERLEAVE_EN
    input  logic               in_dir,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANE_W-1:0]  out_lane,
    output logic [SHIFT_W-1:0] out_shift,
    output logic [4:0]         out_idx,
    output logic               out_last,
    output logic               out_err
);
    import bi_keccak_pkg::*;

    if (LANE_W != 64 || SHIFT_W != $clog2(LANE_W) || NUM_LANES != 25) begin : g_bad_config
        $error("bi_lane_interleaver supports only LANE_W=64, SHIFT_W=6, NUM_LANES=25");
    end

    localparam lane_idx_t LAST_IDX = lane_idx_t'(NUM_LANES - 1);

    lane_idx_t         cnt;
    lane_idx_t         beat_idx;
    logic              beat_err;
    logic              accept;
    logic [LANE_W-1:0] beat_lane;
    s1_beat_t          s1_in;
    s1_beat_t          s1_q;
    s2_beat_t          s2_in;
    s2_beat_t          s2_q;
    logic              s1_valid;
    logic              s2_ready;

    // A misplaced sof or a missing sof both restart the frame at index 0 and flag the beat.
    assign beat_idx = in_sof ? '0 : cnt;
    assign beat_err = in_sof ? (cnt != '0) : (cnt == '0);
    assign accept   = in_valid && in_ready;

`ifdef BI_DEINTERLEAVE_EN
    assign beat_lane = in_dir ? bi_deinterleave(in_lane) : bi_interleave(in_lane);
`else
    assign beat_lane = bi_interleave(in_lane);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (accept)
            cnt <= (beat_idx == LAST_IDX) ? '0 : beat_idx + 1'b1;
    end

    assign s1_in = '{err: beat_err, idx: beat_idx, lane: beat_lane};

    bi_pipe_reg #(.W($bits(s1_beat_t))) u_s1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_q)
    );

    assign s2_in = '{last: (s1_q.idx == LAST_IDX), shift: rho_to_rotr(s1_q.idx), beat: s1_q};

    bi_pipe_reg #(.W($bits(s2_beat_t))) u_s2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign out_lane  = s2_q.beat.lane;
    assign out_idx   = s2_q.beat.idx;
    assign out_err   = s2_q.beat.err;
    assign out_shift = s2_q.shift;
    assign out_last  = s2_q.last;

endmodule
